ip_codma_bus_arbiter: RTL and testbench

- Shares the single CODMA memory bus master between the read machine and the write machine.
- Selects one requester, requests the bus, and hands the granted bus to that requester.
- Counts completed beats and releases the bus at burst end.
- Enforces round-robin fairness, a stop/abort path and an ack-timeout watchdog; sits between the rd/wr machines and the mem_interface master port in the CODMA top level.

---
 rtl/ip_codma_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_ip_codma_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_bus_arbiter.sv
// Shares the CODMA memory bus master between the read and write machines:
// round-robin selection, burst beat counting, stop/error abort and ack watchdog.
module ip_codma_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int BEAT_W         = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rd_req_i,
    input  logic [BEAT_W-1:0] rd_beats_i,
    output logic              rd_grant_o,
    input  logic              wr_req_i,
    input  logic [BEAT_W-1:0] wr_beats_i,
    output logic              wr_grant_o,
    input  logic              stop_i,
    output logic              bus_req_o,
    input  logic              bus_grant_i,
    input  logic              bus_ack_i,
    input  logic              bus_error_i,
    output logic              owner_o,
    output logic [BEAT_W-1:0] beat_count_o,
    output logic              busy_o,
    output logic              timeout_o
);

    // state       | meaning
    // ARB_IDLE    | no request in flight, waiting to select a requester
    // ARB_REQ     | bus_req_o raised for the selected requester
    // ARB_OWN     | bus granted, counting beats under watchdog
    // ARB_RELEASE | one-cycle gap after a completed burst
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_OWN     = 2'd2,
        ARB_RELEASE = 2'd3
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] len_r, len_nxt;
    logic [BEAT_W-1:0] beat_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic              last_owner, last_owner_nxt;
    logic              owner_nxt, timeout_nxt;
    logic              sel_wr, sel_req;
    logic [BEAT_W-1:0] sel_beats;

    // On a tie the requester that was not served last wins.
    assign sel_wr    = wr_req_i && (!rd_req_i || !last_owner);
    assign sel_beats = sel_wr ? wr_beats_i : rd_beats_i;
    assign sel_req   = owner_o ? wr_req_i : rd_req_i;

    always_comb begin
        state_nxt      = state;
        len_nxt        = len_r;
        beat_nxt       = beat_count_o;
        wd_nxt         = wd_cnt;
        last_owner_nxt = last_owner;
        owner_nxt      = owner_o;
        timeout_nxt    = timeout_o;
        if (stop_i) begin
            state_nxt   = ARB_IDLE;
            beat_nxt    = '0;
            timeout_nxt = 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (rd_req_i || wr_req_i) begin
                        state_nxt = ARB_REQ;
                        owner_nxt = sel_wr;
                        len_nxt   = (sel_beats == '0) ? BEAT_W'(1) : sel_beats;
                        beat_nxt  = '0;
                    end
                end
                ARB_REQ: begin
                    if (bus_error_i) begin
                        state_nxt      = ARB_IDLE;
                        last_owner_nxt = owner_o;
                    end else if (!sel_req) begin
                        state_nxt = ARB_IDLE;
                    end else if (bus_grant_i) begin
                        state_nxt = ARB_OWN;
                        wd_nxt    = WD_LOAD;
                    end
                end
                ARB_OWN: begin
                    if (bus_error_i) begin
                        state_nxt      = ARB_IDLE;
                        last_owner_nxt = owner_o;
                    end else if (bus_ack_i) begin
                        beat_nxt = beat_count_o + BEAT_W'(1);
                        wd_nxt   = WD_LOAD;
                        if (beat_count_o == len_r - BEAT_W'(1)) begin
                            state_nxt      = ARB_RELEASE;
                            last_owner_nxt = owner_o;
                        end
                    end else if (wd_cnt == '0) begin
                        state_nxt      = ARB_IDLE;
                        timeout_nxt    = 1'b1;
                        last_owner_nxt = owner_o;
                    end else begin
                        wd_nxt = wd_cnt - WD_W'(1);
                    end
                end
                ARB_RELEASE: state_nxt = ARB_IDLE;
                default:     state_nxt = ARB_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= ARB_IDLE;
            len_r        <= '0;
            beat_count_o <= '0;
            wd_cnt       <= '0;
            last_owner   <= 1'b1;
            owner_o      <= 1'b1;
            timeout_o    <= 1'b0;
            bus_req_o    <= 1'b0;
            rd_grant_o   <= 1'b0;
            wr_grant_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_nxt;
            len_r        <= len_nxt;
            beat_count_o <= beat_nxt;
            wd_cnt       <= wd_nxt;
            last_owner   <= last_owner_nxt;
            owner_o      <= owner_nxt;
            timeout_o    <= timeout_nxt;
            bus_req_o    <= (state_nxt == ARB_REQ) || (state_nxt == ARB_OWN);
            rd_grant_o   <= (state_nxt == ARB_OWN) && !owner_nxt;
            wr_grant_o   <= (state_nxt == ARB_OWN) && owner_nxt;
            busy_o       <= (state_nxt != ARB_IDLE);
        end
    end

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// Self-checking bench for ip_codma_bus_arbiter: directed scenarios plus a
// randomized alternation stress against a transaction-level expectation.
module tb_ip_codma_bus_arbiter;
    localparam int BW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          rd_req_i = 1'b0, wr_req_i = 1'b0;
    logic [BW-1:0] rd_beats_i = '0, wr_beats_i = '0;
    logic          stop_i = 1'b0, bus_grant_i = 1'b0, bus_ack_i = 1'b0, bus_error_i = 1'b0;
    logic          rd_grant_o, wr_grant_o, bus_req_o, owner_o, busy_o, timeout_o;
    logic [BW-1:0] beat_count_o;

    int n_cmp = 0;
    int n_err = 0;

    ip_codma_bus_arbiter #(.TIMEOUT_CYCLES(TO), .BEAT_W(BW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .rd_req_i(rd_req_i), .rd_beats_i(rd_beats_i), .rd_grant_o(rd_grant_o),
        .wr_req_i(wr_req_i), .wr_beats_i(wr_beats_i), .wr_grant_o(wr_grant_o),
        .stop_i(stop_i), .bus_req_o(bus_req_o), .bus_grant_i(bus_grant_i),
        .bus_ack_i(bus_ack_i), .bus_error_i(bus_error_i), .owner_o(owner_o),
        .beat_count_o(beat_count_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        rd_req_i = 1'b0; wr_req_i = 1'b0; stop_i = 1'b0;
        bus_grant_i = 1'b0; bus_ack_i = 1'b0; bus_error_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
    endtask

    // Drives one burst from request to release and checks grant length in acks.
    task automatic run_burst(input logic exp_own, input int exp_len, input string tag);
        int n;
        n = 0;
        while (!bus_req_o && n < 5) begin tick(); n++; end
        n_cmp++;
        if (bus_req_o !== 1'b1 || owner_o !== exp_own) begin
            n_err++;
            $display("FAIL %s_req: bus_req=%0b owner=%0b, expected 1/%0b", tag, bus_req_o, owner_o, exp_own);
        end
        n_cmp++;
        if ((rd_grant_o | wr_grant_o) !== 1'b0) begin
            n_err++;
            $display("FAIL %s_pregrant: grants=%0b%0b, expected 00", tag, wr_grant_o, rd_grant_o);
        end
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        n_cmp++;
        if ({wr_grant_o, rd_grant_o} !== (exp_own ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL %s_grant: wr/rd=%0b%0b, owner expected %0b", tag, wr_grant_o, rd_grant_o, exp_own);
        end
        bus_ack_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while ((rd_grant_o | wr_grant_o) && n < exp_len + 4);
        bus_ack_i = 1'b0;
        n_cmp++;
        if (n !== exp_len) begin
            n_err++;
            $display("FAIL %s_len: grant held for %0d acks, expected %0d", tag, n, exp_len);
        end
        n_cmp++;
        if (beat_count_o !== BW'(exp_len) || busy_o !== 1'b1 || bus_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_release: beats=%0d busy=%0b bus_req=%0b, expected %0d/1/0",
                     tag, beat_count_o, busy_o, bus_req_o, exp_len);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rd_grant_o, wr_grant_o, bus_req_o, busy_o, timeout_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: rd/wr/req/busy/to=%0b%0b%0b%0b%0b, expected 00000",
                     rd_grant_o, wr_grant_o, bus_req_o, busy_o, timeout_o);
        end
        n_cmp++;
        if (beat_count_o !== '0 || owner_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: beats=%0d owner=%0b, expected 0/1", beat_count_o, owner_o);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        rd_beats_i = 8'd4;
        rd_req_i = 1'b1;
        run_burst(1'b0, 4, "single_read");
        rd_req_i = 1'b0;
        tick();
        n_cmp++;
        if (busy_o !== 1'b0 || rd_grant_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_read_idle: busy=%0b grant=%0b, expected 0/0", busy_o, rd_grant_o);
        end
    endtask

    task automatic test_tie();
        do_reset();
        rd_beats_i = 8'd2; wr_beats_i = 8'd6;
        rd_req_i = 1'b1; wr_req_i = 1'b1;
        run_burst(1'b0, 2, "tie_first");
        run_burst(1'b1, 6, "tie_second");
        run_burst(1'b0, 2, "tie_repeat");
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_zero_len();
        do_reset();
        wr_beats_i = 8'd0;
        wr_req_i = 1'b1;
        run_burst(1'b1, 1, "zero_len");
        wr_req_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        wr_beats_i = 8'd5;
        wr_req_i = 1'b1;
        tick();
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        wr_req_i = 1'b0;
        n = 0;
        while (wr_grant_o && n < 3 * TO) begin tick(); n++; end
        n_cmp++;
        if (n !== TO) begin
            n_err++;
            $display("FAIL timeout_len: grant held %0d cycles without ack, expected %0d", n, TO);
        end
        n_cmp++;
        if (timeout_o !== 1'b1 || busy_o !== 1'b0 || bus_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_flags: to=%0b busy=%0b req=%0b, expected 1/0/0", timeout_o, busy_o, bus_req_o);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (timeout_o !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: to=%0b, expected 1", timeout_o);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_cmp++;
        if (timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: to=%0b, expected 0", timeout_o);
        end
    endtask

    task automatic test_error_stop();
        do_reset();
        rd_beats_i = 8'd4;
        rd_req_i = 1'b1;
        tick();
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        bus_ack_i = 1'b1;
        tick(); tick();
        bus_ack_i = 1'b0;
        n_cmp++;
        if (beat_count_o !== 8'd2 || rd_grant_o !== 1'b1) begin
            n_err++;
            $display("FAIL error_mid: beats=%0d grant=%0b, expected 2/1", beat_count_o, rd_grant_o);
        end
        bus_error_i = 1'b1;
        tick();
        bus_error_i = 1'b0;
        rd_req_i = 1'b0;
        n_cmp++;
        if ({rd_grant_o, bus_req_o, busy_o, timeout_o} !== 4'b0 || beat_count_o !== 8'd2) begin
            n_err++;
            $display("FAIL error_abort: grant/req/busy/to=%0b%0b%0b%0b beats=%0d, expected 0000/2",
                     rd_grant_o, bus_req_o, busy_o, timeout_o, beat_count_o);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_cmp++;
        if (beat_count_o !== '0) begin
            n_err++;
            $display("FAIL stop_clear_beats: beats=%0d, expected 0", beat_count_o);
        end
        rd_req_i = 1'b1; wr_req_i = 1'b1;
        tick();
        n_cmp++;
        if (bus_req_o !== 1'b1 || owner_o !== 1'b1) begin
            n_err++;
            $display("FAIL error_owner: req=%0b owner=%0b, expected 1/1", bus_req_o, owner_o);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_cmp++;
        if (bus_req_o !== 1'b0 || busy_o !== 1'b0 || beat_count_o !== '0) begin
            n_err++;
            $display("FAIL stop_in_req: req=%0b busy=%0b beats=%0d, expected 0/0/0", bus_req_o, busy_o, beat_count_o);
        end
        tick();
        n_cmp++;
        if (bus_req_o !== 1'b1 || owner_o !== 1'b1) begin
            n_err++;
            $display("FAIL stop_keeps_last: req=%0b owner=%0b, expected 1/1", bus_req_o, owner_o);
        end
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    task automatic test_withdraw();
        int grants;
        do_reset();
        rd_beats_i = 8'd3;
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        tick();
        n_cmp++;
        if (bus_req_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw_idle: req=%0b busy=%0b, expected 0/0", bus_req_o, busy_o);
        end
        grants = 0;
        bus_grant_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_grant_o || wr_grant_o) grants++;
        end
        bus_grant_i = 1'b0;
        n_cmp++;
        if (grants !== 0) begin
            n_err++;
            $display("FAIL withdraw_nogrant: %0d granted cycles, expected 0", grants);
        end
    endtask

    // Both machines request continuously, so service must alternate read/write
    // and every burst must last exactly its (0->1) beat length.
    task automatic test_stress();
        int bursts, acks, cur_len, gap, excl, cyc;
        logic exp_own, in_g, g;
        logic [BW-1:0] rb, wb;
        do_reset();
        rb = BW'($urandom_range(0, 7));
        wb = BW'($urandom_range(0, 7));
        rd_beats_i = rb; wr_beats_i = wb;
        rd_req_i = 1'b1; wr_req_i = 1'b1;
        exp_own = 1'b0; in_g = 1'b0;
        bursts = 0; acks = 0; cur_len = 0; gap = 0; excl = 0; cyc = 0;
        while (bursts < 40 && cyc < 5000) begin
            tick();
            cyc++;
            if (rd_grant_o && wr_grant_o) excl++;
            g = rd_grant_o | wr_grant_o;
            if (g && !in_g) begin
                in_g = 1'b1;
                acks = 0;
                cur_len = exp_own ? int'(wb) : int'(rb);
                if (cur_len == 0) cur_len = 1;
                n_cmp++;
                if (owner_o !== exp_own || {wr_grant_o, rd_grant_o} !== (exp_own ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL stress_order: burst %0d owner=%0b wr/rd=%0b%0b, expected owner %0b",
                             bursts, owner_o, wr_grant_o, rd_grant_o, exp_own);
                end
            end else if (!g && in_g) begin
                in_g = 1'b0;
                n_cmp++;
                if (acks !== cur_len) begin
                    n_err++;
                    $display("FAIL stress_len: burst %0d took %0d acks, expected %0d", bursts, acks, cur_len);
                end
                n_cmp++;
                if (beat_count_o !== BW'(cur_len)) begin
                    n_err++;
                    $display("FAIL stress_beats: burst %0d beat_count=%0d, expected %0d", bursts, beat_count_o, cur_len);
                end
                bursts++;
                if (exp_own) begin wb = BW'($urandom_range(0, 7)); wr_beats_i = wb; end
                else begin rb = BW'($urandom_range(0, 7)); rd_beats_i = rb; end
                exp_own = ~exp_own;
            end
            bus_grant_i = bus_req_o && !g && ($urandom_range(0, 2) == 0);
            if (g) begin
                bus_ack_i = ($urandom_range(0, 3) != 0) || (gap >= 3);
                if (bus_ack_i) begin acks++; gap = 0; end
                else gap++;
            end else begin
                bus_ack_i = ($urandom_range(0, 3) == 0);
                gap = 0;
            end
        end
        bus_ack_i = 1'b0; bus_grant_i = 1'b0;
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        n_cmp++;
        if (bursts !== 40) begin
            n_err++;
            $display("FAIL stress_progress: %0d bursts completed in %0d cycles, expected 40", bursts, cyc);
        end
        n_cmp++;
        if (excl !== 0 || timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL stress_exclusive: %0d dual-grant cycles, timeout=%0b, expected 0/0", excl, timeout_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_zero_len();
        test_timeout();
        test_error_stop();
        test_withdraw();
        test_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end
endmodule
